// File: rtl/fifo_sync_rd_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_rd_serializer
//  Brief    : Pops wide FWFT FIFO words and emits them as LSB-first
//             valid/ready beats with a per-word last marker.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_rd_serializer #(
   parameter int DATA_WIDTH = 512,
   parameter int OUT_WIDTH  = 64,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_fifo_empty,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   output logic                  o_fifo_ren,
   output logic                  o_valid,
   output logic [OUT_WIDTH-1:0]  o_data,
   output logic                  o_last,
   input  logic                  i_ready,
   output logic [CNT_WIDTH-1:0]  o_words
);

   localparam int                    c_RATIO     = DATA_WIDTH / OUT_WIDTH;
   localparam int                    c_BEAT_W    = $clog2(c_RATIO);
   localparam logic [c_BEAT_W-1:0]   c_LAST_BEAT = c_BEAT_W'(c_RATIO - 1);

   typedef enum logic [0:0] {
      S_EMPTY  = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_hold;
   logic [c_BEAT_W-1:0]   r_beat;
   logic [CNT_WIDTH-1:0]  r_words;

   logic w_last;
   logic w_hs;
   logic w_ren;

   assign w_last = (r_state == S_STREAM) && (r_beat == c_LAST_BEAT);
   assign w_hs   = (r_state == S_STREAM) && i_ready;
   // Pop when idle, or on the last-beat handshake so the next word follows with no bubble.
   assign w_ren  = !i_rst && !i_fifo_empty && ((r_state == S_EMPTY) || (w_hs && w_last));

   assign o_fifo_ren = w_ren;
   assign o_valid    = (r_state == S_STREAM);
   assign o_data     = r_hold[OUT_WIDTH-1:0];
   assign o_last     = w_last;
   assign o_words    = r_words;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state <= S_EMPTY;
         r_hold  <= '0;
         r_beat  <= '0;
         r_words <= '0;
      end else begin
         if (w_ren) begin
            r_hold  <= i_fifo_data;
            r_beat  <= '0;
            r_state <= S_STREAM;
            r_words <= r_words + 1'b1;
         end else if (w_hs && !w_last) begin
            r_hold  <= r_hold >> OUT_WIDTH;
            r_beat  <= r_beat + 1'b1;
         end else if (w_hs) begin
            r_state <= S_EMPTY;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/fifo_sync_rd_serializer.md
# fifo_sync_rd_serializer

Read-side consumer for the team's synchronous FIFO. It pops wide words from the FIFO's first-word-fall-through read port and emits them as a narrower valid/ready beat stream, LSB slice first, with a last-beat marker per word. It sits between a `fifo_sync` instance and narrow downstream logic such as a DMA beat path or a streaming serializer. It sustains one beat per cycle with no bubble between words while the FIFO holds data.

## Interface
- DATA_WIDTH, 512, FIFO word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 64, output beat width; RATIO = DATA_WIDTH/OUT_WIDTH, RATIO ≥ 2.
- CNT_WIDTH, 16, width of popped-word counter.

Ports:
- clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_fifo_empty  in  1  FIFO empty flag.
- i_fifo_data  in  DATA_WIDTH  FIFO head word, combinational fall-through; valid whenever !i_fifo_empty.
- o_fifo_ren  out  1  pop strobe to FIFO; combinational.
- o_valid  out  1  beat valid.
- o_data  out  OUT_WIDTH  beat data.
- o_last  out  1  final beat of current word.
- i_ready  in  1  downstream accepts beat.
- o_words  out  CNT_WIDTH  count of words popped since reset; wraps.

## Operation
- Holding shift register `hold` [DATA_WIDTH], beat index `beat` [clog2(RATIO)], state {EMPTY, STREAM}.
- Handshake `hs` = o_valid & i_ready.
- EMPTY: o_valid=0. If !i_fifo_empty, then o_fifo_ren=1, hold←i_fifo_data, beat←0, go to STREAM.
- STREAM: o_valid=1, o_data=hold[OUT_WIDTH-1:0], o_last=(beat==RATIO-1).
  - hs & !o_last: hold shifts right by OUT_WIDTH, beat+1.
  - hs & o_last & !i_fifo_empty: o_fifo_ren=1, hold←i_fifo_data, beat←0, stay in STREAM (back-to-back).
  - hs & o_last & i_fifo_empty: go to EMPTY.
  - !hs: hold, beat, o_data and o_last are all held stable.
- o_fifo_ren is gated by !i_rst and must never assert while i_fifo_empty=1.
- o_words increments by 1 on every cycle with o_fifo_ren=1; wraps modulo 2^CNT_WIDTH.
- Beat order: beat k carries word bits [(k+1)·OUT_WIDTH-1 : k·OUT_WIDTH].

## Timing
- Reset values: state EMPTY, o_valid 0, o_data 0, o_last 0, o_words 0, o_fifo_ren 0.
- First-beat latency: pop at cycle N (EMPTY, FIFO non-empty), beat 0 valid at N+1.
- Throughput: with i_ready held high and FIFO non-empty, one beat per cycle and RATIO cycles per word, with zero idle cycles between words.
- FIFO empty when the last beat handshakes: o_valid drops at the next cycle. A word arriving later is popped in EMPTY, giving 1 idle cycle minimum.
- i_ready low: no state change. o_valid never deasserts without a handshake.
- Simultaneous FIFO write and our pop: no interaction; the pop uses only the current i_fifo_empty.
- Reset mid-word: remaining beats are discarded and the popped word is lost. The FIFO is reset by its own i_rst; resetting one side alone is permitted but drops data.
- o_fifo_ren is a combinational function of state, i_fifo_empty, i_ready and beat. The FIFO samples it at the next clk edge.

## Test plan
(DATA_WIDTH=32, OUT_WIDTH=8, RATIO=4 unless noted.)
- Single word: FIFO holds 0x44332211, i_ready=1. Required: one o_fifo_ren pulse; beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles, o_last only with 0x44; then o_valid=0; o_words=1.
- Back-to-back: FIFO holds 0xDDCCBBAA and 0x44332211, i_ready=1. Required: 8 consecutive valid beats AA, BB, CC, DD, 11, 22, 33, 44; second pop in the same cycle as the DD handshake; no gap; o_words=2.
- Backpressure: i_ready toggles 1,0,0,1,… mid-word. Required: o_data, o_last and o_valid stay stable during low cycles; no beat is lost or duplicated; o_fifo_ren fires only with the last-beat handshake.
- Empty guard: i_fifo_empty=1 for 20 cycles, including during the last-beat handshake. Required: o_fifo_ren=0 throughout and o_valid=0 after the final beat.
- Reset mid-word: assert i_rst after beat 0x22 is accepted. Required: the next cycle shows o_valid=0, o_last=0, o_data=0, o_words=0, o_fifo_ren=0 during reset; after release, the next FIFO word streams from beat 0.
- Wrap: CNT_WIDTH=4 with 17 words streamed. Required: o_words reads 1 after the 17th pop, with all 68 beats in order.
